// File: rtl/vending_mealy_param_if.sv
`default_nettype none
// ============================================================================
//  Module      : vending_mealy_param_if
//  Description : Coin-acceptor / actuator bundle for the vending controller.
//                The master (coin front end) drives coin and cancel.
//                The slave (controller) drives dispense, change, reject,
//                busy and the current credit.
//  Revision    : 1.0  initial release
// ============================================================================
interface vending_mealy_param_if #(
    parameter int CREDIT_W = 4
);
    logic [1:0]          coin;      // 00 none, 01 nickel, 10 dime, 11 quarter
    logic                cancel;    // refund request
    logic                dispense;  // Mealy: accepted coin completes a vend
    logic                chg5;      // one 5-cent change pulse per cycle
    logic                coin_rej;  // Mealy: coin offered while busy
    logic                busy;      // paying out change/refund
    logic [CREDIT_W-1:0] credit;    // accumulated credit in 5-cent units

    modport master (
        output coin,
        output cancel,
        input  dispense,
        input  chg5,
        input  coin_rej,
        input  busy,
        input  credit
    );

    modport slave (
        input  coin,
        input  cancel,
        output dispense,
        output chg5,
        output coin_rej,
        output busy,
        output credit
    );
endinterface
`default_nettype wire

// File: rtl/vending_mealy_param.sv
`default_nettype none
// ============================================================================
//  Module      : vending_mealy_param
//  Description : Parametrised vending controller. Accumulates nickel, dime
//                and quarter credit against PRICE_UNITS. Dispense is a Mealy
//                output of the completing coin; change is paid back as
//                back-to-back single-cycle chg5 pulses.
//                Optional feature macro: VEND_REFUND_EN (cancel refunds the
//                held credit as chg5 pulses; ignored when undefined).
//  Revision    : 1.0  initial release
// ============================================================================
module vending_mealy_param #(
    parameter int PRICE_UNITS = 4,  // price in 5-cent units, 1..2**CREDIT_W-5
    parameter int CREDIT_W    = 4   // needs 2**CREDIT_W > PRICE_UNITS+4
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    vending_mealy_param_if.slave       bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_PAY   = 2'd2
    } state_t;

    // Price at sum width (for the no-wrap compare) and at register width
    // (for the owed subtraction, whose result always fits CREDIT_W bits).
    localparam logic [CREDIT_W:0]   c_PRICE_W = (CREDIT_W+1)'(PRICE_UNITS);
    localparam logic [CREDIT_W-1:0] c_PRICE_N = CREDIT_W'(PRICE_UNITS);

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CREDIT_W-1:0] owed_q, owed_d;
    logic                chg5_q, busy_q;

    logic [CREDIT_W:0]   w_coin_units;
    logic [CREDIT_W:0]   w_sum;
    logic [CREDIT_W-1:0] w_vend_owed;
    logic                w_coin_valid;
    logic                w_accepting;
    logic                w_vend;
    logic                w_cancel;

`ifdef VEND_REFUND_EN
    assign w_cancel = bus.cancel;
`else
    // Cancel has no effect in this build; the credit is held indefinitely.
    logic unused_cancel;
    assign unused_cancel = bus.cancel;
    assign w_cancel      = 1'b0;
`endif

    // Decode the coin value and form the one-bit-wider sum so it never wraps.
    always_comb begin
        w_coin_units = '0;
        case (bus.coin)
            2'b01:   w_coin_units = (CREDIT_W+1)'(1);
            2'b10:   w_coin_units = (CREDIT_W+1)'(2);
            2'b11:   w_coin_units = (CREDIT_W+1)'(5);
            default: w_coin_units = '0;
        endcase
        w_sum        = {1'b0, credit_q} + w_coin_units;
        // Overpay is at most 4 units, so the low bits hold the exact difference.
        w_vend_owed  = w_sum[CREDIT_W-1:0] - c_PRICE_N;
        w_coin_valid = (bus.coin != 2'b00);
        w_accepting  = (state_q != ST_PAY);
        w_vend       = w_accepting && w_coin_valid && (w_sum >= c_PRICE_W);
    end

    // Next-state, next-credit and next-owed decision for every state.
    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        owed_d   = owed_q;
        case (state_q)
            ST_IDLE, ST_ACCUM: begin
                if (w_vend) begin
                    // A completing coin always wins over a simultaneous cancel.
                    credit_d = '0;
                    owed_d   = w_vend_owed;
                    state_d  = (w_vend_owed != '0) ? ST_PAY : ST_IDLE;
                end else if (w_cancel) begin
                    credit_d = '0;
                    owed_d   = w_sum[CREDIT_W-1:0];
                    state_d  = (w_sum == '0) ? ST_IDLE : ST_PAY;
                end else if (w_coin_valid) begin
                    credit_d = w_sum[CREDIT_W-1:0];
                    state_d  = ST_ACCUM;
                end
            end
            ST_PAY: begin
                // One pulse per cycle; leave after the pulse for the last unit.
                owed_d = owed_q - CREDIT_W'(1);
                if (owed_q <= CREDIT_W'(1)) begin
                    owed_d  = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                credit_d = '0;
                owed_d   = '0;
            end
        endcase
    end

    // State register with registered Moore outputs; reset abandons any payout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            credit_q <= '0;
            owed_q   <= '0;
            chg5_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            owed_q   <= owed_d;
            chg5_q   <= (state_d == ST_PAY);
            busy_q   <= (state_d == ST_PAY);
        end
    end

    assign bus.dispense = w_vend;
    assign bus.coin_rej = !w_accepting && w_coin_valid;
    assign bus.chg5     = chg5_q;
    assign bus.busy     = busy_q;
    assign bus.credit   = credit_q;

endmodule
`default_nettype wire

// File: tb/tb_vending_mealy_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vending_mealy_param
//  Description : Scoreboard bench for vending_mealy_param (PRICE_UNITS=4,
//                CREDIT_W=4). Inputs change on the falling edge; outputs are
//                compared 1 ns later against hand-derived expectations.
//                Refund expectations follow VEND_REFUND_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vending_mealy_param;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    typedef struct packed {
        logic       disp;
        logic       chg;
        logic       rej;
        logic       busy;
        logic [3:0] credit;
    } exp_t;

    exp_t sb_q[$];

    vending_mealy_param_if #(.CREDIT_W(4)) bus ();

    vending_mealy_param #(
        .PRICE_UNITS (4),
        .CREDIT_W    (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pop the oldest expectation and compare it with what the DUT shows now.
    task automatic compare_out(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 0, 1);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_dispense"}, int'(bus.dispense), int'(e.disp));
            check({tag, "_chg5"},     int'(bus.chg5),     int'(e.chg));
            check({tag, "_coin_rej"}, int'(bus.coin_rej), int'(e.rej));
            check({tag, "_busy"},     int'(bus.busy),     int'(e.busy));
            check({tag, "_credit"},   int'(bus.credit),   int'(e.credit));
        end
    endtask

    // One clock of stimulus: drive on the falling edge, record the expected
    // outputs for this cycle, then compare once combinational paths settle.
    task automatic step(input string tag, input logic [1:0] c, input logic can,
                        input logic ed, input logic ec, input logic er,
                        input logic eb, input int ecr);
        exp_t e;
        @(negedge clk);
        bus.coin   = c;
        bus.cancel = can;
        e.disp   = ed;
        e.chg    = ec;
        e.rej    = er;
        e.busy   = eb;
        e.credit = 4'(ecr);
        sb_q.push_back(e);
        #1;
        compare_out(tag);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dispense"}, int'(bus.dispense), 0);
        check({tag, "_chg5"},     int'(bus.chg5),     0);
        check({tag, "_coin_rej"}, int'(bus.coin_rej), 0);
        check({tag, "_busy"},     int'(bus.busy),     0);
        check({tag, "_credit"},   int'(bus.credit),   0);
    endtask

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        bus.coin   = 2'b00;
        bus.cancel = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset_hold");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_all_zero("reset_rel");

        // 1: nickel, nickel, dime -> exact price, no change
        //     tag      coin  can disp chg rej busy credit
        step("t1_n1", 2'b01, 0, 0, 0, 0, 0, 0);
        step("t1_n2", 2'b01, 0, 0, 0, 0, 0, 1);
        step("t1_d",  2'b10, 0, 1, 0, 0, 0, 2);
        step("t1_end",2'b00, 0, 0, 0, 0, 0, 0);
        step("t1_idl",2'b00, 0, 0, 0, 0, 0, 0);

        // 2: quarter from idle -> vend, one change pulse
        step("t2_q",  2'b11, 0, 1, 0, 0, 0, 0);
        step("t2_p1", 2'b00, 0, 0, 1, 0, 1, 0);
        step("t2_end",2'b00, 0, 0, 0, 0, 0, 0);

        // 3: dime then quarter -> three pulses; nickel on 2nd pulse rejected
        step("t3_d",  2'b10, 0, 0, 0, 0, 0, 0);
        step("t3_q",  2'b11, 0, 1, 0, 0, 0, 2);
        step("t3_p1", 2'b00, 0, 0, 1, 0, 1, 0);
        step("t3_p2", 2'b01, 0, 0, 1, 1, 1, 0);
        step("t3_p3", 2'b00, 0, 0, 1, 0, 1, 0);
        step("t3_end",2'b00, 0, 0, 0, 0, 0, 0);

        // 4: credit 3 then cancel
        step("t4_n",  2'b01, 0, 0, 0, 0, 0, 0);
        step("t4_d",  2'b10, 0, 0, 0, 0, 0, 1);
        step("t4_can",2'b00, 1, 0, 0, 0, 0, 3);
`ifdef VEND_REFUND_EN
        step("t4_r1", 2'b00, 0, 0, 1, 0, 1, 0);
        step("t4_r2", 2'b00, 0, 0, 1, 0, 1, 0);
        step("t4_r3", 2'b00, 0, 0, 1, 0, 1, 0);
        step("t4_end",2'b00, 0, 0, 0, 0, 0, 0);
`else
        step("t4_h1", 2'b00, 0, 0, 0, 0, 0, 3);
        step("t4_h2", 2'b00, 1, 0, 0, 0, 0, 3);
        // finish the held credit with a nickel: exact price
        step("t4_n2", 2'b01, 0, 1, 0, 0, 0, 3);
        step("t4_end",2'b00, 0, 0, 0, 0, 0, 0);
`endif

        // cancel with zero credit never pays anything
        step("tz_can",2'b00, 1, 0, 0, 0, 0, 0);
        step("tz_end",2'b00, 0, 0, 0, 0, 0, 0);

        // 5: credit 3 + quarter -> owed 4; reset after the 2nd pulse
        step("t5_n",  2'b01, 0, 0, 0, 0, 0, 0);
        step("t5_d",  2'b10, 0, 0, 0, 0, 0, 1);
        step("t5_q",  2'b11, 0, 1, 0, 0, 0, 3);
        step("t5_p1", 2'b00, 0, 0, 1, 0, 1, 0);
        step("t5_p2", 2'b00, 0, 0, 1, 0, 1, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("t5_rst");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_all_zero("t5_rel");
        step("t5_a1", 2'b00, 0, 0, 0, 0, 0, 0);
        step("t5_a2", 2'b00, 0, 0, 0, 0, 0, 0);
        step("t5_d1", 2'b10, 0, 0, 0, 0, 0, 0);
        step("t5_d2", 2'b10, 0, 1, 0, 0, 0, 2);
        step("t5_end",2'b00, 0, 0, 0, 0, 0, 0);

        // 6: cancel together with a completing dime -> vend wins, no refund
        step("t6_d1", 2'b10, 0, 0, 0, 0, 0, 0);
        step("t6_dc", 2'b10, 1, 1, 0, 0, 0, 2);
        step("t6_e1", 2'b00, 0, 0, 0, 0, 0, 0);
        step("t6_e2", 2'b00, 0, 0, 0, 0, 0, 0);

        check("sb_drained", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
